// File: rtl/div_pkg.sv
// Shared constants for the restoring divider: operand width, iteration count
// and the legacy-compatible FSM state encoding.
package div_pkg;

    localparam int OP_W     = 16;
    localparam int ITER_CNT = 16;

    localparam logic [1:0] RESET_ST = 2'd0;
    localparam logic [1:0] IDLE     = 2'd1;
    localparam logic [1:0] ITER     = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

endpackage

// File: rtl/div_if.sv
// Byte-wide operand/result handshake shared with the multiplier.
// dout_err exists only when DIV_ZERO_CHECK_EN is defined.
interface div_if;

    logic       din_rdy;
    logic [7:0] din_1;
    logic [7:0] din_2;
    logic [7:0] din_3;
    logic [7:0] din_4;
    logic       dout_rdy;
    logic [7:0] dout_1;
    logic [7:0] dout_2;
    logic [7:0] dout_3;
    logic [7:0] dout_4;
`ifdef DIV_ZERO_CHECK_EN
    logic       dout_err;
`endif

    modport master (
        output din_rdy, din_1, din_2, din_3, din_4,
        input  dout_rdy, dout_1, dout_2, dout_3, dout_4
`ifdef DIV_ZERO_CHECK_EN
        , input dout_err
`endif
    );

    modport slave (
        input  din_rdy, din_1, din_2, din_3, din_4,
        output dout_rdy, dout_1, dout_2, dout_3, dout_4
`ifdef DIV_ZERO_CHECK_EN
        , output dout_err
`endif
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, try
// subtracting the divisor, keep the difference only if it is non-negative.
module div_step
    import div_pkg::*;
(
    input  logic [OP_W:0]   rem_i,
    input  logic            bit_i,
    input  logic [OP_W-1:0] dvs_i,
    output logic [OP_W:0]   rem_o,
    output logic            q_o
);

    logic [OP_W+1:0] shifted;
    logic [OP_W+1:0] trial;

    // One guard bit above the 17-bit remainder makes the sign test exact.
    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {2'b00, dvs_i};
        q_o     = ~trial[OP_W+1];
        rem_o   = q_o ? trial[OP_W:0] : shifted[OP_W:0];
    end

endmodule

// File: rtl/div.sv
// Sequential 16-bit unsigned restoring divider, one quotient bit per cycle.
// Define DIV_ZERO_CHECK_EN to add dout_err and short-circuit zero divisors.
module div
    import div_pkg::*;
(
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);

    logic [1:0]      state_q, state_d;
    logic [4:0]      count_q, count_d;
    logic [OP_W-1:0] quo_q, quo_d;
    logic [OP_W:0]   rem_q, rem_d;
    logic [OP_W-1:0] dvs_q, dvs_d;
    logic [31:0]     res_q, res_d;
`ifdef DIV_ZERO_CHECK_EN
    logic            err_q, err_d;
`endif

    logic [OP_W:0]   step_rem;
    logic            step_q;
    logic [OP_W-1:0] in_dvd;
    logic [OP_W-1:0] in_dvs;

    assign in_dvd = {bus.din_1, bus.din_2};
    assign in_dvs = {bus.din_3, bus.din_4};

    div_step u_step (
        .rem_i (rem_q),
        .bit_i (quo_q[OP_W-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
`ifdef DIV_ZERO_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            RESET_ST: state_d = IDLE;
            IDLE: begin
                if (bus.din_rdy) begin
                    quo_d   = in_dvd;
                    dvs_d   = in_dvs;
                    rem_d   = '0;
                    count_d = 5'(ITER_CNT);
                    state_d = ITER;
`ifdef DIV_ZERO_CHECK_EN
                    err_d   = 1'b0;
                    if (in_dvs == '0) begin
                        count_d = '0;
                        res_d   = {16'hFFFF, in_dvd};
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            ITER: begin
                quo_d   = {quo_q[OP_W-2:0], step_q};
                rem_d   = step_rem;
                count_d = count_q - 5'd1;
                // Last step: publish straight from the step outputs.
                if (count_q == 5'd1) begin
                    res_d   = {quo_q[OP_W-2:0], step_q, step_rem[OP_W-1:0]};
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
`ifdef DIV_ZERO_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
`ifdef DIV_ZERO_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.dout_rdy = (state_q == DONE);
    assign bus.dout_1   = res_q[31:24];
    assign bus.dout_2   = res_q[23:16];
    assign bus.dout_3   = res_q[15:8];
    assign bus.dout_4   = res_q[7:0];
`ifdef DIV_ZERO_CHECK_EN
    assign bus.dout_err = err_q & (state_q == DONE);
`endif

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed cases plus randomized operands
// compared against plain integer division.
module tb_div;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    div_if u_if ();

    div u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    function automatic logic [31:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        if (b == 16'd0) return {16'hFFFF, a};
        return {a / b, a % b};
    endfunction

    function automatic int ref_lat(input logic [15:0] b);
`ifdef DIV_ZERO_CHECK_EN
        if (b == 16'd0) return 0;
`endif
        return 16;
    endfunction

    function automatic logic [31:0] dout_word();
        return {u_if.dout_1, u_if.dout_2, u_if.dout_3, u_if.dout_4};
    endfunction

    function automatic logic get_err();
`ifdef DIV_ZERO_CHECK_EN
        return u_if.dout_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic rdy);
        u_if.din_1   = a[15:8];
        u_if.din_2   = a[7:0];
        u_if.din_3   = b[15:8];
        u_if.din_4   = b[7:0];
        u_if.din_rdy = rdy;
    endtask

    // Issue one operation and wait (bounded) for its strobe. lat = -1 on timeout.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int glitch_at,
                          input logic [15:0] ga, input logic [15:0] gb,
                          output logic [31:0] res, output int lat, output logic err);
        res = '0;
        lat = -1;
        err = 1'b0;
        @(negedge clk);
        drive(a, b, 1'b1);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (glitch_at != 0 && n == glitch_at) drive(ga, gb, 1'b1);
            else u_if.din_rdy = 1'b0;
            if (u_if.dout_rdy) begin
                res = dout_word();
                err = get_err();
                lat = n;
                break;
            end
        end
        u_if.din_rdy = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] res, input int lat, input logic err);
        checks++;
        if (res !== ref_div(a, b)) begin
            errors++;
            $display("FAIL %s result %h/%h: got %h expected %h", name, a, b, res, ref_div(a, b));
        end
        checks++;
        if (lat != ref_lat(b)) begin
            errors++;
            $display("FAIL %s latency %h/%h: got %0d expected %0d", name, a, b, lat, ref_lat(b));
        end
`ifdef DIV_ZERO_CHECK_EN
        checks++;
        if (err !== (b == 16'd0)) begin
            errors++;
            $display("FAIL %s dout_err %h/%h: got %b expected %b", name, a, b, err, b == 16'd0);
        end
`else
        if (err) ;
`endif
    endtask

    task automatic test_reset();
        drive(16'd0, 16'd0, 1'b0);
        #2;
        checks++;
        if (u_if.dout_rdy !== 1'b0 || dout_word() !== 32'd0 || get_err() !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b dout=%h err=%b expected rdy=0 dout=0 err=0",
                     u_if.dout_rdy, dout_word(), get_err());
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] av [6] = '{16'd1000, 16'hFFFF, 16'hFFFF, 16'd5, 16'h1234, 16'd10};
        logic [15:0] bv [6] = '{16'd7,    16'h0001, 16'hFFFF, 16'd9, 16'h0000, 16'd3};
        logic [31:0] res;
        int          lat;
        logic        err;
        for (int i = 0; i < 6; i++) begin
            run_op(av[i], bv[i], 0, 16'd0, 16'd0, res, lat, err);
            check_op("directed", av[i], bv[i], res, lat, err);
            @(negedge clk);
            checks++;
            if (u_if.dout_rdy !== 1'b0) begin
                errors++;
                $display("FAIL pulse_width: got dout_rdy=%b expected 0", u_if.dout_rdy);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] res;
        int          lat;
        logic        err;
        run_op(16'd5, 16'd9, 0, 16'd0, 16'd0, res, lat, err);
        check_op("hold_op", 16'd5, 16'd9, res, lat, err);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (dout_word() !== 32'h0000_0005 || u_if.dout_rdy !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d: got dout=%h rdy=%b expected 00000005 rdy=0",
                         i, dout_word(), u_if.dout_rdy);
            end
        end
    endtask

    task automatic test_ignore_midop();
        logic [31:0] res;
        int          lat;
        logic        err;
        int          extra;
        run_op(16'd1000, 16'd7, 5, 16'h55AA, 16'h0003, res, lat, err);
        check_op("ignore_midop", 16'd1000, 16'd7, res, lat, err);
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (u_if.dout_rdy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ignore_extra_pulses: got %0d expected 0", extra);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] res;
        int          lat;
        logic        err;
        int          pulses;
        @(negedge clk);
        drive(16'd1000, 16'd7, 1'b1);
        @(negedge clk);
        u_if.din_rdy = 1'b0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (u_if.dout_rdy !== 1'b0 || dout_word() !== 32'd0 || get_err() !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop_outputs: got rdy=%b dout=%h err=%b expected 0 0 0",
                     u_if.dout_rdy, dout_word(), get_err());
        end
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (u_if.dout_rdy) pulses++;
        end
        checks++;
        if (pulses != 0 || dout_word() !== 32'd0) begin
            errors++;
            $display("FAIL reset_midop_abort: got pulses=%0d dout=%h expected 0 00000000",
                     pulses, dout_word());
        end
        run_op(16'h4321, 16'h0013, 0, 16'd0, 16'd0, res, lat, err);
        check_op("after_reset", 16'h4321, 16'h0013, res, lat, err);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a0, b0, a1, b1;
        int          first_n, second_n;
        logic [31:0] r0, r1;
        a0 = 16'($urandom);
        b0 = 16'($urandom_range(1, 65535));
        a1 = 16'($urandom);
        b1 = 16'($urandom_range(1, 300));
        first_n  = -1;
        second_n = -1;
        r0 = '0;
        r1 = '0;
        @(negedge clk);
        drive(a0, b0, 1'b1);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (u_if.dout_rdy) begin
                if (first_n < 0) begin
                    first_n = n;
                    r0 = dout_word();
                    drive(a1, b1, 1'b1);
                end else begin
                    second_n = n;
                    r1 = dout_word();
                    break;
                end
            end
        end
        u_if.din_rdy = 1'b0;
        checks++;
        if (first_n != 16 || second_n != 34) begin
            errors++;
            $display("FAIL back_to_back_timing: got %0d,%0d expected 16,34", first_n, second_n);
        end
        checks++;
        if (r0 !== ref_div(a0, b0) || r1 !== ref_div(a1, b1)) begin
            errors++;
            $display("FAIL back_to_back_results: got %h,%h expected %h,%h",
                     r0, r1, ref_div(a0, b0), ref_div(a1, b1));
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic [31:0] res;
        int          lat;
        logic        err;
        for (int i = 0; i < 30; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 16'($urandom);
                1:       b = 16'($urandom_range(1, 255));
                2:       b = (i % 5 == 0) ? 16'd0 : 16'($urandom_range(1, 15));
                default: b = (a == 16'hFFFF) ? a : 16'(a + 16'($urandom_range(1, 100)));
            endcase
            run_op(a, b, 0, 16'd0, 16'd0, res, lat, err);
            check_op("random", a, b, res, lat, err);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_ignore_midop();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
